// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word per decode PC,
// waits for the memory response, and strobes o_EN once the word matches
// the PC decode is currently holding. Faults (misaligned PC, bus error,
// response timeout) park the unit until decode moves to a different PC.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_STALL,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_EN,
    output logic        o_IMEM_REQ,
    output logic [31:0] o_IMEM_ADDR,
    input  logic        i_IMEM_GNT,
    input  logic        i_IMEM_RVALID,
    input  logic [31:0] i_IMEM_RDATA,
    input  logic        i_IMEM_ERR,
    output logic        o_FETCH_FAULT,
    output logic [31:0] o_FAULT_ADDR,
    output logic [1:0]  o_FAULT_CAUSE
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_SETTLE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_BUS      = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_addr;
    logic [31:0]        r_instr;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_fault_addr;
    cause_t             r_fault_cause;

    logic               w_pc_match;
    logic               w_pc_misaligned;
    logic               w_timeout;
    logic               w_load_pc;
    logic               w_capture;
    logic               w_fault_set;
    cause_t             w_fault_cause;
    logic [31:0]        w_fault_pc;

    assign w_pc_match      = (i_PC == r_addr);
    assign w_pc_misaligned = (i_PC[1:0] != 2'b00);
    assign w_timeout       = (r_cnt == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every path into REQ funnels through w_load_pc so the
    // misalignment check is applied uniformly and diverts straight to FAULT
    always_comb begin
        w_next        = r_state;
        w_load_pc     = 1'b0;
        w_capture     = 1'b0;
        w_fault_set   = 1'b0;
        w_fault_cause = CAUSE_NONE;
        w_fault_pc    = r_addr;
        case (r_state)
            S_IDLE: begin
                w_load_pc = 1'b1;
            end
            S_REQ: begin
                if (i_IMEM_GNT) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_IMEM_RVALID) begin
                    if (!w_pc_match) begin
                        w_load_pc = 1'b1;
                    end else if (i_IMEM_ERR) begin
                        w_next        = S_FAULT;
                        w_fault_set   = 1'b1;
                        w_fault_cause = CAUSE_BUS;
                    end else begin
                        w_next    = S_ISSUE;
                        w_capture = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next        = S_FAULT;
                    w_fault_set   = 1'b1;
                    w_fault_cause = CAUSE_TIMEOUT;
                end
            end
            S_ISSUE: begin
                if (!w_pc_match) begin
                    w_load_pc = 1'b1;
                end else if (!i_STALL) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_load_pc = 1'b1;
            end
            S_FAULT: begin
                if (i_PC != r_fault_addr) begin
                    w_load_pc = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_load_pc) begin
            if (w_pc_misaligned) begin
                w_next        = S_FAULT;
                w_fault_set   = 1'b1;
                w_fault_cause = CAUSE_MISALIGN;
                w_fault_pc    = i_PC;
            end else begin
                w_next = S_REQ;
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        o_IMEM_REQ    = 1'b0;
        o_EN          = 1'b0;
        o_FETCH_FAULT = 1'b0;
        case (r_state)
            S_REQ:   o_IMEM_REQ    = 1'b1;
            S_ISSUE: o_EN          = w_pc_match && !i_STALL;
            S_FAULT: o_FETCH_FAULT = 1'b1;
            default: ;
        endcase
    end

    // Address, instruction, timeout counter and fault record
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_addr        <= '0;
            r_instr       <= 32'h0000_0013;
            r_cnt         <= '0;
            r_fault_addr  <= '0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            if (w_load_pc) begin
                r_addr <= i_PC;
            end
            if (w_capture) begin
                r_instr <= i_IMEM_RDATA;
            end
            if (r_state == S_REQ && i_IMEM_GNT) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !i_IMEM_RVALID && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fault_set) begin
                r_fault_addr  <= w_fault_pc;
                r_fault_cause <= w_fault_cause;
            end else if (r_state == S_FAULT && w_next != S_FAULT) begin
                r_fault_cause <= CAUSE_NONE;
            end
        end
    end

    assign o_INSTRUCTION = r_instr;
    assign o_IMEM_ADDR   = {r_addr[31:2], 2'b00};
    assign o_FAULT_ADDR  = r_fault_addr;
    assign o_FAULT_CAUSE = r_fault_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random fetch
// transactions, each checked against per-transaction expectations.
module tb_fetch_unit;

    localparam int unsigned TO = 8;

    logic        i_CLK;
    logic        i_RSTn;
    logic [31:0] i_PC;
    logic        i_STALL;
    logic [31:0] o_INSTRUCTION;
    logic        o_EN;
    logic        o_IMEM_REQ;
    logic [31:0] o_IMEM_ADDR;
    logic        i_IMEM_GNT;
    logic        i_IMEM_RVALID;
    logic [31:0] i_IMEM_RDATA;
    logic        i_IMEM_ERR;
    logic        o_FETCH_FAULT;
    logic [31:0] o_FAULT_ADDR;
    logic [1:0]  o_FAULT_CAUSE;

    int          total;
    int          bad;
    logic [31:0] exp_instr;
    logic [31:0] cur_pc;
    logic [31:0] nxt_pc;
    logic [31:0] tmp;

    fetch_unit #(.TIMEOUT(TO)) dut (
        .i_CLK         (i_CLK),
        .i_RSTn        (i_RSTn),
        .i_PC          (i_PC),
        .i_STALL       (i_STALL),
        .o_INSTRUCTION (o_INSTRUCTION),
        .o_EN          (o_EN),
        .o_IMEM_REQ    (o_IMEM_REQ),
        .o_IMEM_ADDR   (o_IMEM_ADDR),
        .i_IMEM_GNT    (i_IMEM_GNT),
        .i_IMEM_RVALID (i_IMEM_RVALID),
        .i_IMEM_RDATA  (i_IMEM_RDATA),
        .i_IMEM_ERR    (i_IMEM_ERR),
        .o_FETCH_FAULT (o_FETCH_FAULT),
        .o_FAULT_ADDR  (o_FAULT_ADDR),
        .o_FAULT_CAUSE (o_FAULT_CAUSE)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_CLK);
        #1;
    endtask

    // One complete fetch starting with the DUT in REQ for pc (i_PC == pc).
    // gd: cycles of grant withheld; we: empty WAIT cycles before rvalid;
    // st: stall cycles in ISSUE; redir: move i_PC to npc inside ISSUE
    // instead of accepting the word.
    task automatic fetch_txn(input logic [31:0] pc, input int unsigned gd,
                             input int unsigned we, input int unsigned st,
                             input logic [31:0] data, input logic [31:0] npc,
                             input bit redir);
        for (int unsigned g = 0; g <= gd; g++) begin
            i_IMEM_GNT    = (g == gd);
            i_IMEM_RVALID = 1'b0;
            #1;
            chk("req_level", o_IMEM_REQ, 1);
            chk("req_addr", o_IMEM_ADDR, pc);
            chk("req_no_en", o_EN, 0);
            chk("req_instr_hold", o_INSTRUCTION, exp_instr);
            cyc();
        end
        i_IMEM_GNT = 1'b0;
        for (int unsigned w = 0; w < we; w++) begin
            #1;
            chk("wait_no_req", o_IMEM_REQ, 0);
            chk("wait_no_en", o_EN, 0);
            cyc();
        end
        i_IMEM_RVALID = 1'b1;
        i_IMEM_RDATA  = data;
        i_IMEM_ERR    = 1'b0;
        #1;
        chk("rvalid_no_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b0;
        i_IMEM_RDATA  = $urandom;
        for (int unsigned s = 0; s < st; s++) begin
            i_STALL = 1'b1;
            #1;
            chk("stall_no_en", o_EN, 0);
            chk("stall_instr", o_INSTRUCTION, data);
            cyc();
        end
        if (redir) begin
            i_STALL = 1'b1;
            i_PC    = npc;
            #1;
            chk("redir_no_en", o_EN, 0);
            cyc();
            i_STALL   = 1'b0;
            exp_instr = data;
        end else begin
            i_STALL = 1'b0;
            #1;
            chk("issue_en", o_EN, 1);
            chk("issue_instr", o_INSTRUCTION, data);
            cyc();
            exp_instr = data;
            i_PC      = npc;
            #1;
            chk("settle_no_en", o_EN, 0);
            chk("settle_no_req", o_IMEM_REQ, 0);
            cyc();
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        exp_instr     = 32'h0000_0013;
        i_RSTn        = 1'b0;
        i_PC          = 32'h0;
        i_STALL       = 1'b0;
        i_IMEM_GNT    = 1'b0;
        i_IMEM_RVALID = 1'b0;
        i_IMEM_RDATA  = 32'h0;
        i_IMEM_ERR    = 1'b0;

        // Reset values
        repeat (3) cyc();
        chk("rst_instr", o_INSTRUCTION, 32'h0000_0013);
        chk("rst_en", o_EN, 0);
        chk("rst_req", o_IMEM_REQ, 0);
        chk("rst_addr", o_IMEM_ADDR, 0);
        chk("rst_fault", o_FETCH_FAULT, 0);
        chk("rst_fault_addr", o_FAULT_ADDR, 0);
        chk("rst_cause", o_FAULT_CAUSE, 0);

        // Single IDLE cycle after release
        i_RSTn = 1'b1;
        #1;
        chk("idle_req", o_IMEM_REQ, 0);
        chk("idle_en", o_EN, 0);
        cyc();

        // Basic fetch at 0, immediate grant, rvalid two cycles after grant
        fetch_txn(32'h0, 0, 1, 0, 32'h0050_0093, 32'h4, 1'b0);
        // Grant withheld three cycles
        fetch_txn(32'h4, 3, 1, 0, $urandom, 32'h8, 1'b0);
        // Four stall cycles in ISSUE
        fetch_txn(32'h8, 0, 2, 4, $urandom, 32'h10, 1'b0);

        // PC moves 0x10 -> 0x80 while waiting: response discarded
        i_IMEM_GNT = 1'b1;
        #1;
        chk("redir_req_addr", o_IMEM_ADDR, 32'h10);
        cyc();
        i_IMEM_GNT = 1'b0;
        i_PC       = 32'h80;
        #1;
        chk("redir_wait_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b1;
        i_IMEM_RDATA  = 32'hDEAD_BEEF;
        #1;
        chk("redir_rvalid_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b0;
        #1;
        chk("redir_instr_kept", o_INSTRUCTION, exp_instr);
        // Fetch at 0x80, then interrupt redirect in ISSUE (beats stall)
        fetch_txn(32'h80, 1, 0, 1, $urandom, 32'h100, 1'b1);
        // Fetch at 0x100, decode then moves to misaligned 0x102
        fetch_txn(32'h100, 0, 0, 0, $urandom, 32'h102, 1'b0);

        // Misaligned fault held while PC stays put
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            chk("mis_fault", o_FETCH_FAULT, 1);
            chk("mis_cause", o_FAULT_CAUSE, 2'b01);
            chk("mis_addr", o_FAULT_ADDR, 32'h102);
            chk("mis_no_req", o_IMEM_REQ, 0);
            chk("mis_no_en", o_EN, 0);
            cyc();
        end
        i_PC = 32'h200;
        cyc();
        #1;
        chk("mis_exit_fault", o_FETCH_FAULT, 0);
        chk("mis_exit_cause", o_FAULT_CAUSE, 0);
        chk("mis_exit_addr", o_IMEM_ADDR, 32'h200);
        chk("mis_exit_req", o_IMEM_REQ, 1);

        // Bus error at 0x200
        i_IMEM_GNT = 1'b1;
        cyc();
        i_IMEM_GNT    = 1'b0;
        i_IMEM_RVALID = 1'b1;
        i_IMEM_ERR    = 1'b1;
        i_IMEM_RDATA  = 32'hBAD0_BAD0;
        #1;
        chk("buserr_no_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b0;
        i_IMEM_ERR    = 1'b0;
        #1;
        chk("buserr_fault", o_FETCH_FAULT, 1);
        chk("buserr_cause", o_FAULT_CAUSE, 2'b10);
        chk("buserr_addr", o_FAULT_ADDR, 32'h200);
        chk("buserr_instr", o_INSTRUCTION, exp_instr);
        cyc();
        i_PC = 32'h300;
        cyc();

        // Timeout at 0x300: TO+1 empty WAIT cycles, then FAULT
        i_IMEM_GNT = 1'b1;
        #1;
        chk("to_req_addr", o_IMEM_ADDR, 32'h300);
        cyc();
        i_IMEM_GNT = 1'b0;
        for (int unsigned k = 0; k <= TO; k++) begin
            #1;
            chk("to_wait_no_fault", o_FETCH_FAULT, 0);
            chk("to_wait_no_req", o_IMEM_REQ, 0);
            cyc();
        end
        #1;
        chk("to_fault", o_FETCH_FAULT, 1);
        chk("to_cause", o_FAULT_CAUSE, 2'b11);
        chk("to_addr", o_FAULT_ADDR, 32'h300);
        i_IMEM_RVALID = 1'b1;
        i_IMEM_RDATA  = 32'h1234_5678;
        #1;
        chk("late_no_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b0;
        #1;
        chk("late_fault_held", o_FETCH_FAULT, 1);
        chk("late_cause_held", o_FAULT_CAUSE, 2'b11);
        chk("late_instr", o_INSTRUCTION, exp_instr);
        i_PC = 32'h400;
        cyc();
        fetch_txn(32'h400, 1, 0, 0, $urandom, 32'h404, 1'b0);

        // Reset in the middle of a WAIT; response in IDLE/REQ ignored
        i_IMEM_GNT = 1'b1;
        cyc();
        i_IMEM_GNT = 1'b0;
        i_RSTn     = 1'b0;
        cyc();
        i_RSTn        = 1'b1;
        i_IMEM_RVALID = 1'b1;
        i_IMEM_RDATA  = 32'hCAFE_F00D;
        i_PC          = 32'h500;
        #1;
        chk("mrst_no_en", o_EN, 0);
        chk("mrst_no_req", o_IMEM_REQ, 0);
        chk("mrst_instr", o_INSTRUCTION, 32'h0000_0013);
        chk("mrst_addr", o_IMEM_ADDR, 0);
        cyc();
        #1;
        chk("mrst_req", o_IMEM_REQ, 1);
        chk("mrst_req_addr", o_IMEM_ADDR, 32'h500);
        chk("mrst_req_no_en", o_EN, 0);
        cyc();
        i_IMEM_RVALID = 1'b0;
        exp_instr     = 32'h0000_0013;
        fetch_txn(32'h500, 0, 1, 1, $urandom, 32'h600, 1'b0);

        // Random transactions
        cur_pc = 32'h600;
        for (int unsigned n = 0; n < 40; n++) begin
            tmp    = $urandom;
            nxt_pc = tmp & 32'hFFFF_FFFC;
            if (nxt_pc == cur_pc) begin
                nxt_pc = nxt_pc ^ 32'h4;
            end
            fetch_txn(cur_pc, $urandom_range(3, 0), $urandom_range(4, 0),
                      $urandom_range(3, 0), $urandom, nxt_pc,
                      ($urandom_range(7, 0) == 0));
            cur_pc = nxt_pc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles WAIT holds after grant before timeout fault.
REQ-002 i_CLK  in  1  clock; every register updates on the rising edge only.
REQ-003 i_RSTn  in  1  reset: i_RSTn, synchronous, active-low; clock i_CLK.
REQ-004 i_PC  in  32  current program counter driven by the decode stage.
REQ-005 i_STALL  in  1  backend hold; o_EN is not asserted while high.
REQ-006 o_INSTRUCTION  out  32  fetched instruction word to decode.
REQ-007 o_EN  out  1  one-cycle strobe: o_INSTRUCTION is valid for i_PC; decode advances.
REQ-008 o_IMEM_REQ  out  1  instruction-memory read request.
REQ-009 o_IMEM_ADDR  out  32  word-aligned read address.
REQ-010 i_IMEM_GNT  in  1  request accepted in the cycle it is high together with o_IMEM_REQ.
REQ-011 i_IMEM_RVALID  in  1  read response valid; at most one response outstanding.
REQ-012 i_IMEM_RDATA  in  32  response data.
REQ-013 i_IMEM_ERR  in  1  response error, qualified by i_IMEM_RVALID.
REQ-014 o_FETCH_FAULT  out  1  fault level, held in FAULT state.
REQ-015 o_FAULT_ADDR  out  32  PC that caused the fault.
REQ-016 o_FAULT_CAUSE  out  2  01 misaligned, 10 bus error, 11 timeout, 00 none.

Function
REQ-017 States IDLE, REQ, WAIT, ISSUE, SETTLE, FAULT; one active at a time.
REQ-018 IDLE: lasts exactly one cycle after reset release, then REQ.
REQ-019 REQ entry: latch i_PC into the address register; if i_PC[1:0] != 0, go FAULT with cause 01 and issue no request.
REQ-020 REQ: o_IMEM_REQ=1, o_IMEM_ADDR=latched address; both held stable until the i_IMEM_GNT cycle, then WAIT.
REQ-021 WAIT: o_IMEM_REQ=0; timeout counter clears on entry and increments each cycle without i_IMEM_RVALID.
REQ-022 WAIT with i_IMEM_RVALID and i_PC != latched address: discard response, re-enter REQ with the new i_PC. This redirect check has priority over error.
REQ-023 WAIT with i_IMEM_RVALID, PC match, i_IMEM_ERR=1: go FAULT with cause 10.
REQ-024 WAIT with i_IMEM_RVALID, PC match, no error: capture i_IMEM_RDATA into o_INSTRUCTION, go ISSUE.
REQ-025 WAIT with counter == TIMEOUT and no i_IMEM_RVALID: go FAULT with cause 11; any later response is ignored.
REQ-026 ISSUE: o_EN=1 combinationally when i_STALL=0 and i_PC == latched address, then SETTLE; o_EN=0 and hold ISSUE while i_STALL=1.
REQ-027 ISSUE with i_PC != latched address (interrupt redirect): o_EN=0, go REQ; redirect beats stall.
REQ-028 SETTLE: one cycle, o_EN=0, lets decode register its new PC, then REQ.
REQ-029 o_EN is never high in two consecutive cycles; load-to-EN latency is 1 cycle after the rvalid cycle.
REQ-030 FAULT: o_FETCH_FAULT=1, o_FAULT_ADDR and o_FAULT_CAUSE held; o_IMEM_REQ=0, o_EN=0.
REQ-031 FAULT exits to REQ when i_PC != o_FAULT_ADDR; on exit, o_FETCH_FAULT=0 and cause=00.
REQ-032 o_INSTRUCTION holds its last value outside WAIT capture.
REQ-033 Address compare uses the full 32 bits; there is no PC arithmetic in this block.

Reset
REQ-034 While i_RSTn=0: state IDLE, o_INSTRUCTION=32'h00000013, o_EN=0, o_IMEM_REQ=0, o_IMEM_ADDR=0, fault outputs 0, counter 0.
REQ-035 Reset mid-transaction drops any outstanding request; a response arriving in IDLE or the next REQ is ignored.

Verification
REQ-036 Reset, i_PC=0, memory grants at once, rvalid 2 cycles later with 32'h00500093 -> o_IMEM_ADDR=0, o_INSTRUCTION=32'h00500093, single o_EN pulse, SETTLE, then a new REQ.
REQ-037 i_GNT low for 3 cycles -> o_IMEM_REQ and o_IMEM_ADDR stable all 3 cycles; no o_EN before rvalid.
REQ-038 i_PC changes 0x10 -> 0x80 during WAIT -> response discarded, next o_IMEM_ADDR=0x80, no o_EN for 0x10.
REQ-039 i_STALL=1 for 4 cycles in ISSUE -> o_EN=0 throughout; o_EN=1 in the first cycle with i_STALL=0.
REQ-040 i_PC=0x102 -> FAULT cause 01, o_FAULT_ADDR=0x102, no request; i_PC=0x200 -> REQ at 0x200.
REQ-041 rvalid with i_IMEM_ERR=1 -> cause 10; no rvalid for TIMEOUT cycles -> cause 11; late rvalid is ignored.
